// File: rtl/pulse_code_pkg.sv
// rtl/pulse_code_pkg.sv - shared types and helpers for the temporal pulse code
// A timed-out window reports value == MAX_VALUE together with the no-spike flag.
package pulse_code_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } pulse_state_e;

   localparam bit NO_SPIKE_FLAG = 1'b1;

   function automatic int value_width(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/decoder_pulse.sv
// rtl/decoder_pulse.sv - decodes a timed active-low pulse into a binary value
// Optional two-sample spike qualification under macro DECODER_PULSE_DEGLITCH_EN.
module decoder_pulse
   import pulse_code_pkg::*;
#(
   parameter int MAX_VALUE = 8,
   localparam int VW = value_width(MAX_VALUE)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          window_start,
   input  logic          incoming_line,
   output logic [VW-1:0] decoded_value,
   output logic          decoded_valid,
   output logic          no_spike,
   output logic          busy
);

   localparam logic [VW-1:0] MAX_CNT = VW'(MAX_VALUE);

   pulse_state_e  state_q, state_d;
   logic [VW-1:0] counter_q, counter_d;
   logic [VW-1:0] value_q, value_d;
   logic          valid_q, valid_d;
   logic          no_spike_q, no_spike_d;
`ifdef DECODER_PULSE_DEGLITCH_EN
   logic          pending_q, pending_d;
   logic [VW-1:0] cand_q, cand_d;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         counter_q  <= '0;
         value_q    <= '0;
         valid_q    <= 1'b0;
         no_spike_q <= 1'b0;
`ifdef DECODER_PULSE_DEGLITCH_EN
         pending_q  <= 1'b0;
         cand_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         value_q    <= value_d;
         valid_q    <= valid_d;
         no_spike_q <= no_spike_d;
`ifdef DECODER_PULSE_DEGLITCH_EN
         pending_q  <= pending_d;
         cand_q     <= cand_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      value_d    = value_q;
      valid_d    = 1'b0;
      no_spike_d = no_spike_q;
`ifdef DECODER_PULSE_DEGLITCH_EN
      pending_d  = pending_q;
      cand_d     = cand_q;
`endif
      case (state_q)
         IDLE: begin
            if (window_start) begin
               counter_d = '0;
               state_d   = COUNT;
`ifdef DECODER_PULSE_DEGLITCH_EN
               pending_d = 1'b0;
`endif
            end
         end
         COUNT: begin
            // A restart outranks any spike sampled on the same edge.
            if (window_start) begin
               counter_d = '0;
`ifdef DECODER_PULSE_DEGLITCH_EN
               pending_d = 1'b0;
            end else if (pending_q) begin
               pending_d = 1'b0;
               if (!incoming_line) begin
                  value_d    = cand_q;
                  no_spike_d = 1'b0;
                  valid_d    = 1'b1;
                  state_d    = IDLE;
               end else if (counter_q == MAX_CNT) begin
                  value_d    = MAX_CNT;
                  no_spike_d = NO_SPIKE_FLAG;
                  valid_d    = 1'b1;
                  state_d    = IDLE;
               end else begin
                  counter_d = counter_q + VW'(1);
               end
            end else if (!incoming_line) begin
               // First low sample only nominates a candidate; counting continues.
               pending_d = 1'b1;
               cand_d    = counter_q;
               if (counter_q != MAX_CNT) begin
                  counter_d = counter_q + VW'(1);
               end
`else
            end else if (!incoming_line) begin
               value_d    = counter_q;
               no_spike_d = 1'b0;
               valid_d    = 1'b1;
               state_d    = IDLE;
`endif
            end else if (counter_q == MAX_CNT) begin
               value_d    = MAX_CNT;
               no_spike_d = NO_SPIKE_FLAG;
               valid_d    = 1'b1;
               state_d    = IDLE;
            end else begin
               counter_d = counter_q + VW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign decoded_value = value_q;
   assign decoded_valid = valid_q;
   assign no_spike      = no_spike_q;
   assign busy          = (state_q == COUNT);

endmodule

// File: tb/tb_decoder_pulse.sv
// tb/tb_decoder_pulse.sv - directed vector bench for decoder_pulse (MAX_VALUE=8)
module tb_decoder_pulse;

   localparam int MAXV = 8;

   logic       clock;
   logic       reset;
   logic       window_start;
   logic       incoming_line;
   logic [3:0] decoded_value;
   logic       decoded_valid;
   logic       no_spike;
   logic       busy;

   int compared   = 0;
   int mismatched = 0;

   decoder_pulse #(.MAX_VALUE(MAXV)) dut (
      .clock         (clock),
      .reset         (reset),
      .window_start  (window_start),
      .incoming_line (incoming_line),
      .decoded_value (decoded_value),
      .decoded_valid (decoded_valid),
      .no_spike      (no_spike),
      .busy          (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int low_edge;
      int hold;
      int exp_value;
      bit exp_ns;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Open a window, drive the line low on edges [low_edge, low_edge+hold), check every cycle.
   task automatic run_window(input int low_edge, input int hold, input int exp_value, input bit exp_ns);
      int decide;
      decide = (low_edge >= 0 && low_edge <= MAXV) ? low_edge : MAXV;
      @(negedge clock);
      window_start  = 1'b1;
      incoming_line = 1'b1;
      @(negedge clock);
      window_start = 1'b0;
      check("busy_open", busy, 1);
      for (int k = 0; k <= decide + 3; k++) begin
         incoming_line = (low_edge >= 0 && k >= low_edge && k < low_edge + hold) ? 1'b0 : 1'b1;
         @(negedge clock);
         check($sformatf("valid_e%0d", k), decoded_valid, (k == decide) ? 1 : 0);
         if (k == decide) begin
            check("value", decoded_value, exp_value);
            check("no_spike", no_spike, exp_ns);
            check("busy_done", busy, 0);
         end else if (k < decide) begin
            check($sformatf("busy_e%0d", k), busy, 1);
         end
      end
      incoming_line = 1'b1;
   endtask

   initial begin
      vec_t vecs[7];
      vecs[0] = '{3, 1, 3, 1'b0};
      vecs[1] = '{-1, 0, 8, 1'b1};
      vecs[2] = '{8, 1, 8, 1'b0};
      vecs[3] = '{0, 1, 0, 1'b0};
      vecs[4] = '{1, 4, 1, 1'b0};
      vecs[5] = '{5, 2, 5, 1'b0};
      vecs[6] = '{7, 1, 7, 1'b0};

      reset         = 1'b1;
      window_start  = 1'b0;
      incoming_line = 1'b1;
      #12;
      check("rst_value", decoded_value, 0);
      check("rst_valid", decoded_valid, 0);
      check("rst_no_spike", no_spike, 0);
      check("rst_busy", busy, 0);
      @(negedge clock);
      reset = 1'b0;

      // Idle ignores the line.
      incoming_line = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("idle_valid", decoded_valid, 0);
         check("idle_busy", busy, 0);
      end
      incoming_line = 1'b1;

`ifndef DECODER_PULSE_DEGLITCH_EN
      for (int i = 0; i < 7; i++) begin
         run_window(vecs[i].low_edge, vecs[i].hold, vecs[i].exp_value, vecs[i].exp_ns);
      end

      // Restart coinciding with a low sample wins; second window decodes to 2.
      @(negedge clock);
      window_start = 1'b1;
      @(negedge clock);
      window_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("rs_pre_valid", decoded_valid, 0);
      end
      incoming_line = 1'b0;
      window_start  = 1'b1;
      @(negedge clock);
      window_start  = 1'b0;
      incoming_line = 1'b1;
      check("rs_restart_valid", decoded_valid, 0);
      check("rs_restart_busy", busy, 1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         check("rs_post_valid", decoded_valid, 0);
      end
      incoming_line = 1'b0;
      @(negedge clock);
      incoming_line = 1'b1;
      check("rs_valid", decoded_valid, 1);
      check("rs_value", decoded_value, 2);
      check("rs_no_spike", no_spike, 0);
      @(negedge clock);
      check("rs_valid_drop", decoded_valid, 0);

      // Reset while counter==4 abandons the window.
      window_start = 1'b1;
      @(negedge clock);
      window_start = 1'b0;
      repeat (4) @(negedge clock);
      check("mr_busy_before", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("mr_busy", busy, 0);
      check("mr_valid", decoded_valid, 0);
      @(negedge clock);
      reset = 1'b0;
      incoming_line = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("mr_after_valid", decoded_valid, 0);
      end
      incoming_line = 1'b1;
      run_window(6, 1, 6, 1'b0);
`else
      // Glitch at edge 2 discarded; spike at edges 5-6 reports 5 after edge 6.
      @(negedge clock);
      window_start = 1'b1;
      @(negedge clock);
      window_start = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         incoming_line = (k == 2 || k == 5 || k == 6) ? 1'b0 : 1'b1;
         @(negedge clock);
         check($sformatf("dg_valid_e%0d", k), decoded_valid, (k == 6) ? 1 : 0);
         if (k == 6) begin
            check("dg_value", decoded_value, 5);
            check("dg_no_spike", no_spike, 0);
         end
      end
      incoming_line = 1'b1;

      // Lone low at edge 8 extends the window by one edge, then times out.
      @(negedge clock);
      window_start = 1'b1;
      @(negedge clock);
      window_start = 1'b0;
      for (int k = 0; k <= 11; k++) begin
         incoming_line = (k == 8) ? 1'b0 : 1'b1;
         @(negedge clock);
         check($sformatf("dt_valid_e%0d", k), decoded_valid, (k == 9) ? 1 : 0);
         if (k == 9) begin
            check("dt_value", decoded_value, 8);
            check("dt_no_spike", no_spike, 1);
         end
      end
      incoming_line = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/decoder_pulse.md
Name: decoder_pulse

Overview:
- Receive side of the temporal pulse code. Converts a single active-low pulse on an idle-high line back into a binary value.
- A window_start strobe opens a measurement window. The number of clock edges until the line is first sampled low becomes the decoded value.
- No pulse within MAX_VALUE+1 edges gives a saturated result, flagged as no-spike.
- Sits between a pulse-coded neuron/column output and binary consumers (counters, accumulators, readout).

Parameters:
- MAX_VALUE, 8: largest decodable value. Window spans values 0..MAX_VALUE. Value width VW = $clog2(MAX_VALUE+1).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- window_start  input  1  one-cycle strobe; opens or restarts a measurement window
- incoming_line  input  1  pulse line; idle 1, spike = 0 (synchronous to clock)
- decoded_value  output  VW  last decoded value; held until next result
- decoded_valid  output  1  one-cycle strobe; decoded_value/no_spike valid this cycle
- no_spike  output  1  qualified by decoded_valid; 1 = window expired without a pulse
- busy  output  1  1 while a window is open (state COUNT)

Behaviour:
- Reset (async, active-high):
  - Enters IDLE; counter=0.
  - decoded_value=0, decoded_valid=0, no_spike=0, busy=0.
  - Reset mid-window abandons the measurement; no result is produced.
- All outputs are registered.
- States: IDLE, COUNT.
- IDLE:
  - incoming_line is ignored.
  - window_start=1 at an edge: counter<=0, go to COUNT.
- COUNT, evaluated at each edge in priority order:
  1. window_start=1: counter<=0, stay in COUNT. No result is emitted, even if the line is low this edge (restart wins).
  2. incoming_line=0: decoded_value<=counter, no_spike<=0, decoded_valid<=1, go to IDLE.
  3. counter==MAX_VALUE (line high): decoded_value<=MAX_VALUE, no_spike<=1, decoded_valid<=1, go to IDLE.
  4. Otherwise: counter<=counter+1.
- Timing:
  - Line low at the first edge after the window_start edge decodes to 0.
  - Low k edges later decodes to k.
  - Low exactly at counter==MAX_VALUE decodes to MAX_VALUE with no_spike=0.
- decoded_valid is high for exactly one cycle, in the cycle after the deciding edge.
- Only the first low sample counts. Later low samples in the same window are ignored because the block is back in IDLE.
- A pulse that began before window_start (line already low at the first COUNT edge) decodes to 0.
- Counter never exceeds MAX_VALUE, so no wrap-around.
- busy = (state==COUNT).

Optional Feature:
- Macro DECODER_PULSE_DEGLITCH_EN.
- Without the macro: behaviour exactly as above; single-sample detection.
- With the macro, a spike needs two consecutive low samples in COUNT:
  - First low sample: set pending, latch candidate=counter, keep counting (counter saturates at MAX_VALUE).
  - Next edge low: emit candidate, no_spike=0.
  - Next edge high: clear pending and discard the glitch.
  - Timeout fires at counter==MAX_VALUE only when nothing is pending. A low sample at counter==MAX_VALUE extends the window by exactly one edge.
  - window_start clears pending.
  - Decoded value is still the first-low edge index, so latency grows by one cycle but values are unchanged.

Decomposition:
- Shared package pulse_code_pkg holds:
  - state enum {IDLE, COUNT}
  - function value_width(max) = $clog2(max+1), shared with encoder_pulse
  - NO_SPIKE sentinel convention (value==MAX_VALUE with flag)
- No sub-module. Single always_ff FSM plus counter. The deglitch logic stays inline under the macro.

Test Plan (MAX_VALUE=8):
- Reset, then window_start at cycle 0, line low for one cycle sampled at edge 3 -> decoded_valid one cycle, decoded_value=3, no_spike=0; busy low afterwards.
- window_start, line held high -> after 9 COUNT edges, decoded_value=8, no_spike=1, decoded_valid one cycle.
- window_start, line low at edge 8 (counter==8) -> decoded_value=8, no_spike=0.
- window_start, line low at edge 5 in the same cycle as a second window_start -> no valid; restart, low again at edge 2 -> value 2.
- Assert reset while counter=4 -> busy=0, no decoded_valid ever; following window decodes normally (low at edge 6 -> 6).
- With DECODER_PULSE_DEGLITCH_EN:
  - one-cycle low at edge 2, then two-cycle low at edges 5-6 -> value 5, valid at edge 6;
  - window_start, line high until a one-cycle low at edge 8 -> no_spike=1 after edge 9.
